// File: rtl/snax_dream_pkg.sv
// Shared widths and parameter helpers for the DREAM streamer/accelerator glue.
package snax_dream_pkg;

   localparam int unsigned DreamStreamWidth = 512;
   localparam int unsigned DreamBeatWidth   = 128;

   function automatic int unsigned dream_ratio(input int unsigned in_w, input int unsigned out_w);
      return in_w / out_w;
   endfunction

   function automatic bit dream_widths_legal(input int unsigned in_w, input int unsigned out_w);
      return (out_w != 0) && (in_w >= out_w) && ((in_w % out_w) == 0);
   endfunction

endpackage

// File: rtl/snax_dream_word_fifo.sv
// Register FIFO of wide words; head entry is always visible on rdata_o.
module snax_dream_word_fifo #(
   parameter int unsigned Width = 512,
   parameter int unsigned Depth = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           push_i,
   input  logic [Width-1:0]               wdata_i,
   input  logic                           pop_i,
   output logic [Width-1:0]               rdata_o,
   output logic [$clog2(Depth + 1)-1:0]   count_o,
   output logic                           full_o,
   output logic                           empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
      if (push_i) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      // Flush only rewinds the pointers; stale storage is never visible while empty.
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/snax_dream_stream_serializer.sv
// Buffers wide streamer words and emits them as narrow beats, LSB slice first,
// counting fully delivered words with a saturating counter.
module snax_dream_stream_serializer
   import snax_dream_pkg::*;
#(
   parameter int unsigned InWidth   = DreamStreamWidth,
   parameter int unsigned OutWidth  = DreamBeatWidth,
   parameter int unsigned FifoDepth = 2,
   parameter int unsigned CntWidth  = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [InWidth-1:0]  in_data_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic [OutWidth-1:0] out_data_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                out_last_o,
   input  logic                flush_i,
   output logic [CntWidth-1:0] word_cnt_o
);

   localparam int unsigned Ratio  = dream_ratio(InWidth, OutWidth);
   localparam int unsigned IdxW   = (Ratio > 1) ? $clog2(Ratio) : 1;
   localparam int unsigned FCntW  = $clog2(FifoDepth + 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

   if (!dream_widths_legal(InWidth, OutWidth)) begin : g_illegal_widths
      $error("InWidth must be a non-zero integer multiple of OutWidth");
   end

   logic [InWidth-1:0]  head;
   logic [FCntW-1:0]    fifo_count;
   logic                fifo_full_unused;
   logic                fifo_empty;
   logic                push, out_hs, last_hs;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   assign in_ready_o  = (fifo_count < FCntW'(FifoDepth)) & ~flush_i & ~rst_i;
   assign push        = in_valid_i & in_ready_o;
   assign out_valid_o = ~fifo_empty;
   assign out_hs      = out_valid_o & out_ready_i & ~flush_i & ~rst_i;
   assign last_hs     = out_hs & (idx_q == LastIdx);

   snax_dream_word_fifo #(
      .Width (InWidth),
      .Depth (FifoDepth)
   ) i_word_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push),
      .wdata_i (in_data_i),
      .pop_i   (last_hs),
      .rdata_o (head),
      .count_o (fifo_count),
      .full_o  (fifo_full_unused),
      .empty_o (fifo_empty)
   );

   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      if (out_hs) begin
         idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      end
      if (last_hs && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (flush_i) begin
         idx_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q <= '0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_data_o = head[idx_q*OutWidth +: OutWidth];
   assign out_last_o = out_valid_o & (idx_q == LastIdx);
   assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_snax_dream_stream_serializer.sv
// Bench for the stream serializer: queue-of-words reference model plus per-feature scenarios.
module tb_snax_dream_stream_serializer;

   localparam int IW = 512;
   localparam int OW = 128;
   localparam int R  = IW / OW;
   localparam int D  = 2;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [IW-1:0] in_data;
   logic          in_ready, out_valid, out_last;
   logic [OW-1:0] out_data;
   logic [31:0]   word_cnt;
   logic          s_in_ready, s_out_valid, s_out_last;
   logic [OW-1:0] s_out_data;
   logic [3:0]    s_word_cnt;

   always #5 clk = ~clk;

   snax_dream_stream_serializer #(
      .InWidth (IW), .OutWidth (OW), .FifoDepth (D), .CntWidth (32)
   ) dut (
      .clk_i (clk), .rst_i (rst), .in_data_i (in_data), .in_valid_i (in_valid),
      .in_ready_o (in_ready), .out_data_o (out_data), .out_valid_o (out_valid),
      .out_ready_i (out_ready), .out_last_o (out_last), .flush_i (flush),
      .word_cnt_o (word_cnt)
   );

   // Narrow-counter twin fed with identical stimulus, used for saturation.
   snax_dream_stream_serializer #(
      .InWidth (IW), .OutWidth (OW), .FifoDepth (D), .CntWidth (4)
   ) dut_sat (
      .clk_i (clk), .rst_i (rst), .in_data_i (in_data), .in_valid_i (in_valid),
      .in_ready_o (s_in_ready), .out_data_o (s_out_data), .out_valid_o (s_out_valid),
      .out_ready_i (out_ready), .out_last_o (s_out_last), .flush_i (flush),
      .word_cnt_o (s_word_cnt)
   );

   int            total = 0;
   int            bad   = 0;
   logic [IW-1:0] exp_q[$];
   int            mdl_idx = 0;
   int unsigned   mdl_cnt = 0;
   logic          obs_valid, obs_in_ready;
   logic [OW-1:0] obs_data;

   function automatic logic [IW-1:0] rand_word();
      logic [IW-1:0] w;
      for (int i = 0; i < IW / 32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   // One clock: compare outputs with the model mid-cycle, then advance the model across the edge.
   task automatic step();
      logic [IW-1:0] hw;
      logic [OW-1:0] es;
      logic [3:0]    esat;
      bit            ev, er, do_push;
      @(negedge clk);
      ev = (exp_q.size() != 0);
      er = (exp_q.size() < D) && !flush && !rst;
      esat = (mdl_cnt > 15) ? 4'd15 : mdl_cnt[3:0];
      obs_valid = out_valid; obs_in_ready = in_ready; obs_data = out_data;
      total++; if (out_valid !== ev) begin bad++; $display("FAIL out_valid: got %b want %b", out_valid, ev); end
      total++; if (in_ready !== er) begin bad++; $display("FAIL in_ready: got %b want %b", in_ready, er); end
      total++; if (word_cnt !== mdl_cnt) begin bad++; $display("FAIL word_cnt: got %0d want %0d", word_cnt, mdl_cnt); end
      total++; if (s_word_cnt !== esat) begin bad++; $display("FAIL sat_cnt: got %0d want %0d", s_word_cnt, esat); end
      if (ev) begin
         hw = exp_q[0];
         es = hw[mdl_idx*OW +: OW];
         total++; if (out_data !== es) begin bad++; $display("FAIL out_data: got %h want %h", out_data, es); end
         total++; if (out_last !== (mdl_idx == R - 1)) begin bad++; $display("FAIL out_last: got %b want %b", out_last, (mdl_idx == R - 1)); end
      end else begin
         total++; if (out_last !== 1'b0) begin bad++; $display("FAIL out_last_idle: got %b want 0", out_last); end
      end
      if (rst || flush) begin
         exp_q.delete(); mdl_idx = 0; mdl_cnt = 0;
      end else begin
         do_push = in_valid && (exp_q.size() < D);
         if (ev && out_ready) begin
            if (mdl_idx == R - 1) begin
               void'(exp_q.pop_front());
               mdl_idx = 0;
               if (mdl_cnt != 32'hffff_ffff) mdl_cnt++;
            end else begin
               mdl_idx++;
            end
         end
         if (do_push) exp_q.push_back(in_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_words(input int n, input bit bp, output int beats, output int span,
                             output int accepts, output int unstable, output bit timed_out);
      int sent = 0, cyc = 0, first = -1, lastc = 0;
      bit will_push, prev_stall = 0;
      logic [OW-1:0] prev_data = '0;
      logic [IW-1:0] cur = rand_word();
      beats = 0; accepts = 0; unstable = 0;
      while ((sent < n || exp_q.size() != 0) && cyc < 400) begin
         in_valid  = (sent < n);
         in_data   = cur;
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         will_push = in_valid && (exp_q.size() < D);
         step();
         if (obs_valid && out_ready) begin
            beats++; if (first < 0) first = cyc; lastc = cyc;
         end
         if (obs_in_ready && in_valid) accepts++;
         if (prev_stall && obs_data !== prev_data) unstable++;
         prev_stall = obs_valid && !out_ready;
         prev_data  = obs_data;
         if (will_push) begin sent++; cur = rand_word(); end
         cyc++;
      end
      in_valid  = 1'b0;
      span      = (first < 0) ? 0 : lastc - first + 1;
      timed_out = (cyc >= 400);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      @(posedge clk); #1;
      step();
      rst = 1'b0; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      total++; if (word_cnt !== 32'd0) begin bad++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
   endtask

   task automatic test_single_word();
      int unsigned base = mdl_cnt;
      in_data = {128'd3, 128'd2, 128'd1, 128'd0};
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0; #1;
      for (int k = 0; k < R; k++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid beat %0d: got %b want 1", k, out_valid); end
         total++; if (out_data !== OW'(k)) begin bad++; $display("FAIL single_data beat %0d: got %h want %h", k, out_data, OW'(k)); end
         total++; if (out_last !== (k == R - 1)) begin bad++; $display("FAIL single_last beat %0d: got %b want %b", k, out_last, (k == R - 1)); end
         step();
      end
      total++; if (word_cnt !== base + 1) begin bad++; $display("FAIL single_cnt: got %0d want %0d", word_cnt, base + 1); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      int beats, span, accepts, unstable;
      bit to;
      int unsigned base = mdl_cnt;
      send_words(8, 1'b0, beats, span, accepts, unstable, to);
      total++; if (to) begin bad++; $display("FAIL b2b_timeout: got timeout want completion"); end
      total++; if (beats !== 8 * R) begin bad++; $display("FAIL b2b_beats: got %0d want %0d", beats, 8 * R); end
      total++; if (span !== 8 * R) begin bad++; $display("FAIL b2b_span: got %0d want %0d", span, 8 * R); end
      total++; if (accepts !== 8) begin bad++; $display("FAIL b2b_accepts: got %0d want 8", accepts); end
      total++; if (word_cnt !== base + 8) begin bad++; $display("FAIL b2b_cnt: got %0d want %0d", word_cnt, base + 8); end
   endtask

   task automatic test_backpressure();
      int beats, span, accepts, unstable;
      bit to;
      int unsigned base = mdl_cnt;
      for (int rep = 0; rep < 4; rep++) begin
         send_words(3, 1'b1, beats, span, accepts, unstable, to);
         total++; if (to) begin bad++; $display("FAIL bp_timeout rep %0d: got timeout want completion", rep); end
         total++; if (beats !== 3 * R) begin bad++; $display("FAIL bp_beats rep %0d: got %0d want %0d", rep, beats, 3 * R); end
         total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable rep %0d: got %0d changes want 0", rep, unstable); end
      end
      total++; if (word_cnt !== base + 12) begin bad++; $display("FAIL bp_cnt: got %0d want %0d", word_cnt, base + 12); end
   endtask

   task automatic test_flush();
      logic [IW-1:0] wc = rand_word();
      out_ready = 1'b1;
      in_data = rand_word(); in_valid = 1'b1; step();
      in_data = rand_word(); step();
      in_valid = 1'b0; step();
      flush = 1'b1; in_valid = 1'b1; in_data = rand_word(); step();
      flush = 1'b0; in_valid = 1'b0; #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      total++; if (word_cnt !== 32'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", word_cnt); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", in_ready); end
      in_data = wc; in_valid = 1'b1; out_ready = 1'b0; step();
      in_valid = 1'b0; #1;
      total++; if (out_data !== wc[OW-1:0]) begin bad++; $display("FAIL flush_new_slice0: got %h want %h", out_data, wc[OW-1:0]); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL flush_new_last: got %b want 0", out_last); end
      out_ready = 1'b1;
      for (int i = 0; i < R; i++) step();
   endtask

   task automatic test_rst_mid();
      out_ready = 1'b1;
      in_data = rand_word(); in_valid = 1'b1; step();
      in_valid = 1'b0; step();
      rst = 1'b1; step();
      rst = 1'b0; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      total++; if (word_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", word_cnt); end
      total++; if (s_word_cnt !== 4'd0) begin bad++; $display("FAIL rst_sat_cnt: got %0d want 0", s_word_cnt); end
      in_data = rand_word(); in_valid = 1'b1; step();
      in_valid = 1'b0;
      for (int i = 0; i < R; i++) step();
   endtask

   task automatic test_saturation();
      int beats, span, accepts, unstable;
      bit to;
      rst = 1'b1; step(); rst = 1'b0;
      send_words(17, 1'b0, beats, span, accepts, unstable, to);
      total++; if (to) begin bad++; $display("FAIL sat_timeout: got timeout want completion"); end
      total++; if (s_word_cnt !== 4'd15) begin bad++; $display("FAIL sat_value: got %0d want 15", s_word_cnt); end
      total++; if (word_cnt !== 32'd17) begin bad++; $display("FAIL sat_wide_cnt: got %0d want 17", word_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_rst_mid();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
